// File: rtl/ddr2_local_cmd_adapter.sv
// Adapts valid/ready command, write-data and read-response streams onto the
// DDR2 controller's Avalon-style local_* interface, all in the phy_clk domain.
module ddr2_local_cmd_adapter #(
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned BE_W      = 32,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned RSP_DEPTH = 16
) (
    input  logic              phy_clk,
    input  logic              reset_phy_clk,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              err_sticky,
    input  logic              local_init_done,
    input  logic              local_ready,
    output logic [ADDR_W-1:0] local_address,
    output logic [2:0]        local_size,
    output logic              local_burstbegin,
    output logic              local_read_req,
    output logic              local_write_req,
    output logic [DATA_W-1:0] local_wdata,
    output logic [BE_W-1:0]   local_be,
    input  logic              local_rdata_valid,
    input  logic [DATA_W-1:0] local_rdata
);

    localparam int unsigned PTR_W  = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned USED_W = CNT_W + 2;
    localparam logic [2:0]  MAX_SZ = 3'(MAX_BURST);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RD,
        WR
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [2:0]        loaded;
    logic [2:0]        retired;
    logic              beat_valid;
    logic [DATA_W-1:0] beat_data;
    logic [BE_W-1:0]   beat_be;

    logic [DATA_W-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  outstanding;

    logic [2:0]        eff_size;
    logic              size_illegal;
    logic [USED_W-1:0] credit_need;
    logic              credit_ok;
    logic              accept;
    logic              wr_take;
    logic              wr_retire;
    logic              rd_issue;
    logic              fifo_empty;
    logic              fifo_full;
    logic              rsp_pop;
    logic              push_ok;
    logic              out_dec;

    always_comb begin
        eff_size     = cmd_size;
        size_illegal = 1'b0;
        if (cmd_size == 3'd0) begin
            eff_size     = 3'd1;
            size_illegal = 1'b1;
        end else if (cmd_size > MAX_SZ) begin
            eff_size     = MAX_SZ;
            size_illegal = 1'b1;
        end
    end

    // Credit test phrased as used+need <= depth so it can never underflow.
    always_comb begin
        credit_need = USED_W'(fifo_count) + USED_W'(outstanding) + USED_W'(eff_size);
        credit_ok   = (credit_need <= USED_W'(RSP_DEPTH));
    end

    always_ff @(posedge phy_clk) begin
        if (reset_phy_clk) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT: if (local_init_done) state_next = IDLE;
            IDLE: if (accept) state_next = cmd_write ? WR : RD;
            RD:   if (rd_issue) state_next = IDLE;
            WR:   if (wr_retire && (retired + 3'd1 == size_q)) state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        cmd_ready        = (state == IDLE) && (cmd_write || credit_ok);
        wr_ready         = (state == WR) && (loaded < size_q) && (!beat_valid || local_ready);
        local_read_req   = (state == RD);
        local_write_req  = (state == WR) && beat_valid;
        local_burstbegin = (state == RD) || ((state == WR) && beat_valid && (retired == 3'd0));
        accept           = cmd_valid && cmd_ready;
        wr_take          = wr_valid && wr_ready;
        wr_retire        = local_write_req && local_ready;
        rd_issue         = local_read_req && local_ready;
    end

    assign local_address = addr_q;
    assign local_size    = size_q;
    assign local_wdata   = beat_data;
    assign local_be      = beat_be;

    always_ff @(posedge phy_clk) begin
        if (reset_phy_clk) begin
            addr_q     <= '0;
            size_q     <= '0;
            loaded     <= '0;
            retired    <= '0;
            beat_valid <= 1'b0;
            beat_data  <= '0;
            beat_be    <= '0;
        end else begin
            if (accept) begin
                addr_q     <= cmd_addr;
                size_q     <= eff_size;
                loaded     <= '0;
                retired    <= '0;
                beat_valid <= 1'b0;
            end
            // A new beat may load in the same cycle the held beat retires.
            if (wr_take) begin
                beat_valid <= 1'b1;
                beat_data  <= wr_data;
                beat_be    <= wr_be;
                loaded     <= loaded + 3'd1;
            end else if (wr_retire) begin
                beat_valid <= 1'b0;
            end
            if (wr_retire) begin
                retired <= retired + 3'd1;
            end
        end
    end

    always_comb begin
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == CNT_W'(RSP_DEPTH));
        rsp_pop    = !fifo_empty && rsp_ready;
        push_ok    = local_rdata_valid && (!fifo_full || rsp_pop);
        out_dec    = local_rdata_valid && (outstanding != '0);
    end

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge phy_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= local_rdata;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (reset_phy_clk) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            err_sticky  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rsp_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, rsp_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            outstanding <= outstanding
                         + (rd_issue ? CNT_W'(size_q) : '0)
                         - (out_dec ? CNT_W'(1) : '0);
            if ((accept && size_illegal)
                || (local_rdata_valid && (outstanding == '0))
                || (local_rdata_valid && fifo_full && !rsp_pop)) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_local_cmd_adapter.sv
// Scoreboard bench for ddr2_local_cmd_adapter: directed stimulus pushes expected
// local_* requests and response beats; a negedge monitor pops and compares.
module tb_ddr2_local_cmd_adapter;

    logic         phy_clk = 1'b0;
    logic         reset_phy_clk;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [24:0]  cmd_addr;
    logic [2:0]   cmd_size;
    logic         wr_valid, wr_ready;
    logic [255:0] wr_data;
    logic [31:0]  wr_be;
    logic         rsp_valid, rsp_ready;
    logic [255:0] rsp_data;
    logic         err_sticky;
    logic         local_init_done, local_ready;
    logic [24:0]  local_address;
    logic [2:0]   local_size;
    logic         local_burstbegin, local_read_req, local_write_req;
    logic [255:0] local_wdata;
    logic [31:0]  local_be;
    logic         local_rdata_valid;
    logic [255:0] local_rdata;

    typedef struct {
        logic [24:0]  addr;
        logic [2:0]   size;
        logic         bb;
        logic [255:0] data;
        logic [31:0]  be;
    } wexp_t;

    typedef struct {
        logic [24:0] addr;
        logic [2:0]  size;
    } rexp_t;

    wexp_t        wq[$];
    rexp_t        rq[$];
    logic [255:0] rspq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_hs = 0;
    int rd_cyc = 0;

    always #5 phy_clk = ~phy_clk;

    ddr2_local_cmd_adapter #(
        .ADDR_W(25), .DATA_W(256), .BE_W(32), .MAX_BURST(4), .RSP_DEPTH(16)
    ) dut (
        .phy_clk(phy_clk), .reset_phy_clk(reset_phy_clk),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .err_sticky(err_sticky),
        .local_init_done(local_init_done), .local_ready(local_ready),
        .local_address(local_address), .local_size(local_size),
        .local_burstbegin(local_burstbegin), .local_read_req(local_read_req),
        .local_write_req(local_write_req), .local_wdata(local_wdata), .local_be(local_be),
        .local_rdata_valid(local_rdata_valid), .local_rdata(local_rdata)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] wd(input int k);
        logic [31:0] w;
        w = 32'hA000_0000 + 32'(k);
        return {8{w}};
    endfunction

    function automatic logic [31:0] wb(input int k);
        return 32'h0F0F_0F00 | 32'(k);
    endfunction

    function automatic logic [255:0] rdv(input int k);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(k);
        return {8{w}};
    endfunction

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [24:0] a, input logic [2:0] sz);
        int n;
        n = 0;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_accept_wait", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_rdata(input logic [255:0] d);
        local_rdata_valid = 1'b1;
        local_rdata       = d;
        tick();
        local_rdata_valid = 1'b0;
    endtask

    always @(negedge phy_clk) begin
        wexp_t we;
        rexp_t re;
        if (!reset_phy_clk) begin
            if (local_write_req) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", local_write_req, 0);
                end else begin
                    we = wq[0];
                    chk("wr_addr", local_address, we.addr);
                    chk("wr_size", local_size, we.size);
                    chk("wr_burstbegin", local_burstbegin, we.bb);
                    if (local_ready) begin
                        chk("wr_data", local_wdata, we.data);
                        chk("wr_be", local_be, we.be);
                        void'(wq.pop_front());
                        wr_hs++;
                    end
                end
            end
            if (local_read_req) begin
                rd_cyc++;
                if (rq.size() == 0) begin
                    chk("rd_unexpected", local_read_req, 0);
                end else begin
                    re = rq[0];
                    chk("rd_addr", local_address, re.addr);
                    chk("rd_size", local_size, re.size);
                    chk("rd_burstbegin", local_burstbegin, 1);
                    if (local_ready) void'(rq.pop_front());
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rspq.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    chk("rsp_data", rsp_data, rspq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, c, bad;
        logic acc;

        reset_phy_clk = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_size = 3'd1;
        wr_valid = 0; wr_data = '0; wr_be = '0; rsp_ready = 0;
        local_init_done = 0; local_ready = 1; local_rdata_valid = 0; local_rdata = '0;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_reqs", {local_read_req, local_write_req, local_burstbegin}, 0);
        reset_phy_clk = 1'b0;

        // Init gating
        cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cmd_ready || local_read_req || local_write_req) bad++;
        end
        chk("init_gate", bad, 0);
        cmd_valid = 1'b0;
        local_init_done = 1'b1;
        c = 0;
        tick();
        while (!cmd_ready && c < 3) begin
            tick();
            c++;
        end
        chk("init_release", cmd_ready, 1);

        // Write burst, size 4 at 0x100, local_ready low on cycles 2-3
        for (int i = 0; i < 4; i++)
            wq.push_back('{addr: 25'h100, size: 3'd4, bb: (i == 0), data: wd(i), be: wb(i)});
        wr_hs = 0;
        send_cmd(1'b1, 25'h100, 3'd4);
        k = 0; c = 0;
        while ((k < 4 || wq.size() != 0) && c < 40) begin
            wr_valid    = (k < 4);
            wr_data     = wd(k);
            wr_be       = wb(k);
            local_ready = !(c == 2 || c == 3);
            @(negedge phy_clk);
            acc = wr_valid & wr_ready;
            @(posedge phy_clk);
            #1;
            if (acc) k++;
            c++;
        end
        wr_valid = 1'b0;
        local_ready = 1'b1;
        chk("wr_burst_drained", wq.size(), 0);
        chk("wr_handshakes", wr_hs, 4);
        chk("wr_back_to_idle", cmd_ready, 1);

        // Read size 2 at 0x1ABCDEF, 3 cycles of backpressure
        rsp_ready = 1'b1;
        rq.push_back('{addr: 25'h1ABCDEF, size: 3'd2});
        send_cmd(1'b0, 25'h1ABCDEF, 3'd2);
        rd_cyc = 0;
        local_ready = 1'b0;
        repeat (3) tick();
        local_ready = 1'b1;
        tick();
        chk("rd_hold_cycles", rd_cyc, 4);
        chk("rd_issued", rq.size(), 0);
        rspq.push_back(rdv(0));
        rspq.push_back(rdv(1));
        push_rdata(rdv(0));
        push_rdata(rdv(1));
        repeat (3) tick();
        chk("rd_rsp_drained", rspq.size(), 0);

        // Credit stall
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rq.push_back('{addr: 25'(32'h400 + 4 * i), size: 3'd4});
            send_cmd(1'b0, 25'(32'h400 + 4 * i), 3'd4);
            tick();
        end
        cmd_write = 1'b0;
        cmd_size  = 3'd4;
        #1;
        chk("credit_stall_outstanding", cmd_ready, 0);
        for (int j = 0; j < 16; j++) begin
            rspq.push_back(rdv(100 + j));
            push_rdata(rdv(100 + j));
        end
        chk("credit_stall_full", cmd_ready, 0);
        chk("credit_fifo_valid", rsp_valid, 1);
        chk("credit_no_err", err_sticky, 0);
        rsp_ready = 1'b1;
        repeat (4) tick();
        rsp_ready = 1'b0;
        chk("credit_popped4", rspq.size(), 12);
        chk("credit_release", cmd_ready, 1);
        rsp_ready = 1'b1;
        repeat (14) tick();
        chk("credit_drained", rspq.size(), 0);

        // Illegal sizes
        chk("err_before_illegal", err_sticky, 0);
        rq.push_back('{addr: 25'h55, size: 3'd1});
        send_cmd(1'b0, 25'h55, 3'd0);
        tick();
        chk("err_size0", err_sticky, 1);
        rspq.push_back(rdv(200));
        push_rdata(rdv(200));
        rq.push_back('{addr: 25'h66, size: 3'd4});
        send_cmd(1'b0, 25'h66, 3'd7);
        tick();
        for (int j = 0; j < 4; j++) begin
            rspq.push_back(rdv(210 + j));
            push_rdata(rdv(210 + j));
        end
        repeat (3) tick();
        chk("illegal_rsp_drained", rspq.size(), 0);
        chk("err_still_set", err_sticky, 1);

        // Leave a read in flight and a beat buffered, then reset mid-write
        rsp_ready = 1'b0;
        rq.push_back('{addr: 25'h77, size: 3'd2});
        send_cmd(1'b0, 25'h77, 3'd2);
        tick();
        push_rdata(rdv(300));
        for (int i = 0; i < 2; i++)
            wq.push_back('{addr: 25'h200, size: 3'd4, bb: (i == 0), data: wd(10 + i), be: wb(10 + i)});
        send_cmd(1'b1, 25'h200, 3'd4);
        k = 0; c = 0;
        while ((k < 2 || wq.size() != 0) && c < 20) begin
            wr_valid = (k < 2);
            wr_data  = wd(10 + k);
            wr_be    = wb(10 + k);
            @(negedge phy_clk);
            acc = wr_valid & wr_ready;
            @(posedge phy_clk);
            #1;
            if (acc) k++;
            c++;
        end
        wr_valid = 1'b0;
        chk("rstw_beats_done", wq.size(), 0);
        reset_phy_clk = 1'b1;
        tick();
        chk("rstw_cmd_ready", cmd_ready, 0);
        chk("rstw_wr_ready", wr_ready, 0);
        chk("rstw_rsp_valid", rsp_valid, 0);
        chk("rstw_err", err_sticky, 0);
        chk("rstw_reqs", {local_read_req, local_write_req, local_burstbegin}, 0);
        chk("rstw_addr", local_address, 0);
        chk("rstw_size", local_size, 0);
        chk("rstw_wdata", local_wdata, 0);
        chk("rstw_be", local_be, 0);
        reset_phy_clk = 1'b0;
        cmd_write = 1'b0;
        cmd_size  = 3'd4;
        #1;
        chk("rstw_state_init", cmd_ready, 0);
        tick();
        chk("rstw_idle", cmd_ready, 1);
        rspq.push_back(rdv(400));
        push_rdata(rdv(400));
        chk("err_spurious_rdata", err_sticky, 1);
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("rstw_fifo_fresh", rspq.size(), 0);

        chk("final_wq_empty", wq.size(), 0);
        chk("final_rq_empty", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
